// File: rtl/plab5_mcore_mem_port_sep_if.sv
// Split-message memory port: request (control/data/domain) and response channels.
// master = requester side, slave = memory bank side.
interface plab5_mcore_mem_port_sep_if #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 128
);
    localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + 4;
    localparam int c_resp_nbits = 3 + p_opaque_nbits + 4;

    logic [c_req_nbits-1:0]  memreq_control;
    logic [p_data_nbits-1:0] memreq_data;
    logic                    memreq_domain;
    logic                    memreq_val;
    logic                    memreq_rdy;

    logic [c_resp_nbits-1:0] memresp_control;
    logic [p_data_nbits-1:0] memresp_data;
    logic                    memresp_domain;
    logic                    memresp_val;
    logic                    memresp_rdy;

    modport master (
        output memreq_control, memreq_data, memreq_domain, memreq_val,
        input  memreq_rdy,
        input  memresp_control, memresp_data, memresp_domain, memresp_val,
        output memresp_rdy
    );

    modport slave (
        input  memreq_control, memreq_data, memreq_domain, memreq_val,
        output memreq_rdy,
        output memresp_control, memresp_data, memresp_domain, memresp_val,
        input  memresp_rdy
    );
endinterface

// File: rtl/plab5_mcore_mem_port_sep.sv
// Domain-tagged test-memory bank with a 2-entry response queue and partition enforcement.
// Optional: define PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN to expose a saturating viol_count output.
module plab5_mcore_mem_port_sep #(
    parameter int p_mem_nbytes   = 256,
    parameter int p_bank_domain  = 0,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 128
) (
    input  logic clk,
    input  logic reset,
    plab5_mcore_mem_port_sep_if.slave mem
`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
    ,
    output logic [15:0] viol_count
`endif
);
    localparam int c_lines        = p_mem_nbytes / 16;
    localparam int c_idx_nbits    = (c_lines > 1) ? $clog2(c_lines) : 1;
    localparam int c_line_nbytes  = p_data_nbits / 8;
    localparam int c_req_nbits    = 3 + p_opaque_nbits + p_addr_nbits + 4;
    localparam int c_resp_nbits   = 3 + p_opaque_nbits + 4;

    // Request decode
    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [p_addr_nbits-1:0]   req_addr;
    logic [3:0]                req_len;
    logic [3:0]                req_off;
    logic [c_idx_nbits-1:0]    line_idx;
    logic [4:0]                wr_nbytes;
    logic [4:0]                wr_end;
    logic [p_data_nbits-1:0]   wr_data_shift;
    logic                      unused_addr;

    assign req_type    = mem.memreq_control[c_req_nbits-1 -: 3];
    assign req_opaque  = mem.memreq_control[c_req_nbits-4 -: p_opaque_nbits];
    assign req_addr    = mem.memreq_control[4 +: p_addr_nbits];
    assign req_len     = mem.memreq_control[3:0];
    assign unused_addr = ^req_addr;

    // Upper address bits are dropped so addresses alias modulo the bank size
    assign line_idx  = req_addr[4 +: c_idx_nbits] & c_idx_nbits'(c_lines - 1);
    assign req_off   = req_addr[3:0];
    assign wr_nbytes = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
    assign wr_end    = {1'b0, req_off} + wr_nbytes;

    // Write data is low-justified; byte i lands at line byte off+i, bytes past 15 fall off
    assign wr_data_shift = mem.memreq_data << {req_off, 3'b000};

    logic is_read;
    logic is_write;
    logic d2_into_d1;
    logic d1_from_d2;
    logic accept;
    logic wr_en;

    assign is_read    = (req_type == 3'd0);
    assign is_write   = (req_type == 3'd1) || (req_type == 3'd2);
    assign d2_into_d1 = (p_bank_domain == 0) && mem.memreq_domain;
    assign d1_from_d2 = (p_bank_domain == 1) && !mem.memreq_domain;

    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       head_reg;
    logic       tail_reg;
    logic       deq;

    assign mem.memreq_rdy = (count_reg != 2'd2);
    assign accept         = mem.memreq_val && mem.memreq_rdy;
    assign wr_en          = accept && is_write && !d2_into_d1;

    // Storage: one byte-wide array per lane gives natural byte enables
    logic [p_data_nbits-1:0] rd_line;

    genvar gi;
    generate
        for (gi = 0; gi < c_line_nbytes; gi++) begin : g_lane
            localparam logic [4:0] c_lane = 5'(gi);
            logic [7:0] lane_mem [0:c_lines-1];
            logic       byte_en;

            assign byte_en = wr_en && (c_lane >= {1'b0, req_off}) && (c_lane < wr_end);

            always_ff @(posedge clk) begin
                if (byte_en) begin
                    lane_mem[line_idx] <= wr_data_shift[8*gi +: 8];
                end
            end

            assign rd_line[8*gi +: 8] = lane_mem[line_idx];
        end
    endgenerate

    logic [c_resp_nbits-1:0] rsp_ctrl;
    logic [p_data_nbits-1:0] rsp_data;

    assign rsp_ctrl = {req_type, req_opaque, req_len};
    assign rsp_data = (is_read && !d1_from_d2) ? rd_line : '0;

    // Response queue; the entry registers act as the registered read port
    logic [c_resp_nbits-1:0] q_ctrl_reg [2];
    logic [p_data_nbits-1:0] q_data_reg [2];
    logic                    q_dom_reg  [2];

    assign deq = (count_reg != 2'd0) && mem.memresp_rdy;

    always_comb begin
        count_next = count_reg;
        case ({accept, deq})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_ctrl_reg[i] <= '0;
                q_data_reg[i] <= '0;
                q_dom_reg[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                q_ctrl_reg[tail_reg] <= rsp_ctrl;
                q_data_reg[tail_reg] <= rsp_data;
                q_dom_reg[tail_reg]  <= mem.memreq_domain;
                tail_reg             <= ~tail_reg;
            end
            if (deq) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_next;
        end
    end

    assign mem.memresp_control = q_ctrl_reg[head_reg];
    assign mem.memresp_data    = q_data_reg[head_reg];
    assign mem.memresp_domain  = q_dom_reg[head_reg];
    assign mem.memresp_val     = (count_reg != 2'd0);

`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
    logic        viol;
    logic [15:0] viol_count_reg;

    assign viol = accept && ((is_write && d2_into_d1) || (is_read && d1_from_d2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            viol_count_reg <= 16'd0;
        end else if (viol && (viol_count_reg != 16'hFFFF)) begin
            viol_count_reg <= viol_count_reg + 16'd1;
        end
    end

    assign viol_count = viol_count_reg;
`endif
endmodule

// File: tb/tb_plab5_mcore_mem_port_sep.sv
// Bench for plab5_mcore_mem_port_sep: a D1 bank and a D2 bank driven from a vector table
// plus hand sequences for back-pressure and mid-operation reset; responses checked via scoreboard.
module tb_plab5_mcore_mem_port_sep;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    plab5_mcore_mem_port_sep_if i0 ();
    plab5_mcore_mem_port_sep_if i1 ();

`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
    logic [15:0] viol0;
    logic [15:0] viol1;
`endif

    plab5_mcore_mem_port_sep #(.p_mem_nbytes(256), .p_bank_domain(0)) dut0 (
        .clk   (clk),
        .reset (reset_n),
        .mem   (i0)
`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
        ,
        .viol_count (viol0)
`endif
    );

    plab5_mcore_mem_port_sep #(.p_mem_nbytes(256), .p_bank_domain(1)) dut1 (
        .clk   (clk),
        .reset (reset_n),
        .mem   (i1)
`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
        ,
        .viol_count (viol1)
`endif
    );

    typedef struct {
        logic [14:0]  ctrl;
        logic [127:0] data;
        logic         dom;
    } rsp_t;

    typedef struct {
        int           sel;
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
        logic         dom;
        logic [7:0]   opq;
        logic [127:0] exp_data;
    } vec_t;

    localparam logic [127:0] D1   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] D1P  = 128'h0123456789abcdeffedcbabeef543210;
    localparam logic [127:0] D0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DSUB = 128'h33442233445566778899aabbccddeeff;
    localparam logic [127:0] DX   = 128'hcafef00d_deadbeef_0badc0de_12345678;
    localparam logic [127:0] AA   = {16{8'hAA}};
    localparam logic [127:0] V55  = {16{8'h55}};
    localparam logic [127:0] FF   = {128{1'b1}};

    rsp_t q0[$];
    rsp_t q1[$];
    rsp_t pend;
    int   pend_sel = 0;
    bit   acc_flag = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    vec_t vecs[18];

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_pop(int sel, logic [14:0] c, logic [127:0] d, logic dm);
        rsp_t e;
        n_vec++;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            n_miss++;
            $display("FAIL resp%0d_unexpected: got ctrl %h data %h, want no response", sel, c, d);
            return;
        end
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        if (c !== e.ctrl || d !== e.data || dm !== e.dom) begin
            n_miss++;
            $display("FAIL resp%0d: got ctrl %h data %h dom %b, want ctrl %h data %h dom %b",
                     sel, c, d, dm, e.ctrl, e.data, e.dom);
        end else begin
            $display("resp%0d ctrl %h data %h dom %b ok", sel, c, d, dm);
        end
    endtask

    // One cycle: observe at the falling edge, then return just after the rising edge
    task automatic tick();
        @(negedge clk);
        if (reset_n) begin
            if (i0.memresp_val && i0.memresp_rdy)
                check_pop(0, i0.memresp_control, i0.memresp_data, i0.memresp_domain);
            if (i1.memresp_val && i1.memresp_rdy)
                check_pop(1, i1.memresp_control, i1.memresp_data, i1.memresp_domain);
            if (pend_sel == 0 && i0.memreq_val && i0.memreq_rdy) begin
                q0.push_back(pend);
                acc_flag = 1'b1;
            end
            if (pend_sel == 1 && i1.memreq_val && i1.memreq_rdy) begin
                q1.push_back(pend);
                acc_flag = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int sel, logic [2:0] typ, logic [31:0] addr, logic [3:0] len,
                           logic [127:0] data, logic dom, logic [7:0] opq, logic [127:0] exp_data);
        pend.ctrl = {typ, opq, len};
        pend.data = exp_data;
        pend.dom  = dom;
        pend_sel  = sel;
        acc_flag  = 1'b0;
        if (sel == 0) begin
            i0.memreq_control = {typ, opq, addr, len};
            i0.memreq_data    = data;
            i0.memreq_domain  = dom;
            i0.memreq_val     = 1'b1;
        end else begin
            i1.memreq_control = {typ, opq, addr, len};
            i1.memreq_data    = data;
            i1.memreq_domain  = dom;
            i1.memreq_val     = 1'b1;
        end
        $display("req%0d type %0d addr %h len %0d dom %b opq %h data %h", sel, typ, addr, len, dom, opq, data);
    endtask

    task automatic clr_req();
        i0.memreq_val = 1'b0;
        i1.memreq_val = 1'b0;
    endtask

    task automatic send(int sel, logic [2:0] typ, logic [31:0] addr, logic [3:0] len,
                        logic [127:0] data, logic dom, logic [7:0] opq, logic [127:0] exp_data);
        set_req(sel, typ, addr, len, data, dom, opq, exp_data);
        for (int k = 0; k < 20 && !acc_flag; k++) tick();
        if (!acc_flag) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: req%0d opq %h not accepted within 20 cycles", sel, opq);
        end
        clr_req();
    endtask

    initial begin
        vecs[0]  = '{0, 3'd1, 32'h020, 4'd0, D1,            1'b0, 8'h01, 128'd0};
        vecs[1]  = '{0, 3'd0, 32'h020, 4'd0, 128'd0,        1'b0, 8'h02, D1};
        vecs[2]  = '{0, 3'd1, 32'h040, 4'd0, 128'd0,        1'b0, 8'h03, 128'd0};
        vecs[3]  = '{0, 3'd1, 32'h040, 4'd0, FF,            1'b1, 8'h04, 128'd0};
        vecs[4]  = '{0, 3'd0, 32'h040, 4'd0, 128'd0,        1'b0, 8'h05, 128'd0};
        vecs[5]  = '{0, 3'd0, 32'h020, 4'd0, 128'd0,        1'b1, 8'h06, D1};
        vecs[6]  = '{0, 3'd3, 32'h020, 4'd0, FF,            1'b0, 8'h07, 128'd0};
        vecs[7]  = '{0, 3'd0, 32'h020, 4'd0, 128'd0,        1'b0, 8'h08, D1};
        vecs[8]  = '{0, 3'd2, 32'h000, 4'd0, D0,            1'b0, 8'h09, 128'd0};
        vecs[9]  = '{0, 3'd1, 32'h00E, 4'd4, 128'h11223344, 1'b0, 8'h0A, 128'd0};
        vecs[10] = '{0, 3'd0, 32'h10E, 4'd0, 128'd0,        1'b0, 8'h0B, DSUB};
        vecs[11] = '{0, 3'd1, 32'h023, 4'd2, 128'hbeef,     1'b0, 8'h0C, 128'd0};
        vecs[12] = '{0, 3'd0, 32'h020, 4'd0, 128'd0,        1'b0, 8'h0D, D1P};
        vecs[13] = '{1, 3'd1, 32'h060, 4'd0, AA,            1'b1, 8'h10, 128'd0};
        vecs[14] = '{1, 3'd0, 32'h060, 4'd0, 128'd0,        1'b0, 8'h11, 128'd0};
        vecs[15] = '{1, 3'd0, 32'h060, 4'd0, 128'd0,        1'b1, 8'h12, AA};
        vecs[16] = '{1, 3'd1, 32'h070, 4'd0, V55,           1'b0, 8'h13, 128'd0};
        vecs[17] = '{1, 3'd0, 32'h070, 4'd0, 128'd0,        1'b1, 8'h14, V55};

        reset_n = 1'b0;
        i0.memreq_control = '0; i0.memreq_data = '0; i0.memreq_domain = 1'b0;
        i0.memreq_val = 1'b0;   i0.memresp_rdy = 1'b1;
        i1.memreq_control = '0; i1.memreq_data = '0; i1.memreq_domain = 1'b0;
        i1.memreq_val = 1'b0;   i1.memresp_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("rst_val0",  i0.memresp_val, 0);
        chk("rst_ctrl0", i0.memresp_control, 0);
        chk("rst_data0", i0.memresp_data, 0);
        chk("rst_dom1",  i1.memresp_domain, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_rdy0", i0.memreq_rdy, 1);
        chk("rst_rdy1", i1.memreq_rdy, 1);
`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
        chk("rst_viol0", viol0, 0);
        chk("rst_viol1", viol1, 0);
`endif

        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].typ, vecs[i].addr, vecs[i].len,
                 vecs[i].data, vecs[i].dom, vecs[i].opq, vecs[i].exp_data);
            chk($sformatf("latency_v%0d", i),
                (vecs[i].sel == 0) ? i0.memresp_val : i1.memresp_val, 1);
            tick();
        end

`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
        chk("viol0_after_table", viol0, 1);
        chk("viol1_after_table", viol1, 1);
`endif

        // Back-pressure: three back-to-back requests with the response side stalled
        i0.memresp_rdy = 1'b0;
        set_req(0, 3'd0, 32'h020, 4'd0, 128'd0, 1'b0, 8'h20, D1P);
        tick();
        set_req(0, 3'd0, 32'h040, 4'd0, 128'd0, 1'b0, 8'h21, 128'd0);
        tick();
        chk("bp_rdy_after_2", i0.memreq_rdy, 0);
        set_req(0, 3'd0, 32'h000, 4'd0, 128'd0, 1'b0, 8'h22, DSUB);
        tick();
        tick();
        chk("bp_third_held", acc_flag, 0);
        i0.memresp_rdy = 1'b1;
        chk("bp_no_bypass", i0.memreq_rdy, 0);
        tick();
        chk("bp_rdy_after_deq", i0.memreq_rdy, 1);
        chk("bp_third_not_yet", acc_flag, 0);
        tick();
        chk("bp_third_accepted", acc_flag, 1);
        clr_req();
        tick();
        tick();

        // Reset with two responses queued
        i0.memresp_rdy = 1'b0;
        send(0, 3'd1, 32'h080, 4'd0, DX, 1'b0, 8'h30, 128'd0);
        send(0, 3'd0, 32'h020, 4'd0, 128'd0, 1'b0, 8'h31, D1P);
        chk("rq_full_rdy", i0.memreq_rdy, 0);
        reset_n = 1'b0;
        #1;
        chk("rq_rst_val", i0.memresp_val, 0);
        chk("rq_rst_data", i0.memresp_data, 0);
        chk("rq_rst_ctrl", i0.memresp_control, 0);
        q0.delete();
        q1.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rq_rdy_release", i0.memreq_rdy, 1);
        chk("rq_val_release", i0.memresp_val, 0);
`ifdef PLAB5_MCORE_MEM_PORT_VIOL_CNT_EN
        chk("rq_viol0_cleared", viol0, 0);
`endif
        i0.memresp_rdy = 1'b1;
        send(0, 3'd0, 32'h080, 4'd0, 128'd0, 1'b0, 8'h32, DX);
        tick();
        tick();

        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
